csr_timer_bank: RTL
===================

CSR_TIMER_BANK -- requirements
Module: csr_timer_bank

Interface
REQ-001 SHALL have parameter NCH, default 4, number of timer channels (1..16).
REQ-002 SHALL have parameter TW, default 32, counter width in bits (8..32).
REQ-003 SHALL have parameter PSW, default 8, prescaler width in bits.
REQ-004 SHALL use one clock and a synchronous, active-high reset; ports are listed below.
REQ-005 SHALL have port clk, input, 1, the sole clock.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port addr, input, 8, CSR select.
REQ-008 SHALL have port we, input, 1, write enable.
REQ-009 SHALL have port wdata, input, 32, write data.
REQ-010 SHALL have port wmask, input, 32, per-bit write mask.
REQ-011 SHALL have port rdata, output, 32, read data.
REQ-012 SHALL have port stop, input, 1, debug freeze.
REQ-013 SHALL have port irq_pending, output, NCH, per-channel pending flags.
REQ-014 SHALL have port irq, output, 1, the OR of (irq_pending & IMASK).

Function
REQ-015 SHALL decode the following address map.
- Channel i, base 4*i: +0 TCFG {InitVal[TW-1:2], Periodic, En}, RW.
- Channel i, +1 TVAL, RO; writes are ignored.
- Channel i, +2 TICLR, write-1-to-bit0 clears that channel's pending flag; reads 0.
- 0xF0 PRESC[PSW-1:0], RW.
- 0xF1 IMASK[NCH-1:0], RW.
- 0xF2 ISTAT, RO, returns irq_pending zero-extended.
REQ-016 SHALL make rdata combinational on addr, with zero latency, zero-extended; unmapped or reserved addresses read 0.
REQ-017 SHALL update every RW field as new = (wmask & wdata) | (~wmask & old).
REQ-018 SHALL generate the shared tick from a prescaler counter pcnt.
- tick = (pcnt == PRESC) && !stop.
- On tick, pcnt resets to 0; otherwise pcnt increments, unless stop is high, in which case pcnt holds.
- PRESC = 0 yields a tick every cycle.
REQ-019 SHALL reset pcnt to 0 on any write to PRESC.
REQ-020 SHALL load TVAL with {merged InitVal, 2'b00} in the same clock edge as a TCFG write whose merged En is 1.
REQ-021 SHALL give each enabled channel the following per-tick behaviour.
- If TVAL != 0, TVAL decrements by 1.
- If TVAL == 0 (timeout), pending is set.
- On timeout with Periodic = 1, TVAL reloads {InitVal, 2'b00}.
- On timeout with Periodic = 0, TVAL becomes all-ones and En clears (one-shot stop).
REQ-022 SHALL leave TVAL, pending and En unchanged on cycles with a disabled channel or no tick.
REQ-023 SHALL let set win when a timeout and a TICLR clear hit the same channel in the same cycle, so pending stays 1.
REQ-024 SHALL let the write decide TVAL, En and Periodic when a TCFG write and a timeout hit the same channel in the same cycle; the timeout's pending set still occurs.
REQ-025 SHALL allow TCFG writes while stop is high, and SHALL apply the TVAL load of REQ-020.
REQ-026 SHALL drive irq combinationally from the registered pending flags and IMASK.
REQ-027 SHALL have no wrap-around from 0 to all-ones other than the one-shot rule of REQ-021.

Reset
REQ-028 SHALL on reset set the following values.
- All TVAL to all-ones.
- En = 0, Periodic = 0 and InitVal = 0 for every channel.
- pending = 0, IMASK = 0, PRESC = 0 and pcnt = 0.
REQ-029 SHALL hold irq_pending = 0 and irq = 0 from the cycle after reset is asserted; reset asserted mid-count SHALL abort the count with no timeout.

Structure
REQ-030 SHALL place the address offsets (TCFG, TVAL, TICLR) and the global addresses (PRESC, IMASK, ISTAT) in the shared package alongside the existing CSR numbers.
REQ-031 SHALL implement one channel (TCFG, TVAL, pending logic) as sub-module timer_channel, instantiated NCH times by a generate loop.
REQ-032 SHALL keep the prescaler, the address decode and the read mux in csr_timer_bank.

Verification
REQ-033 SHALL test one-shot: PRESC=0, write ch0 TCFG = 0x0000_0011 (InitVal=4, so TVAL=16) -> TVAL reads 16,15,..,0 on consecutive cycles, then pending[0]=1 one cycle later, TVAL=0xFFFF_FFFF, En=0.
REQ-034 SHALL test periodic: ch1 TCFG = 0x0000_000B (TVAL=8), IMASK=0x2 -> irq pulses every 9 ticks; after TICLR write 1, irq falls next cycle and re-asserts at the next timeout.
REQ-035 SHALL test the prescaler: PRESC=3, ch0 TVAL=4 -> timeout after 20 clocks; raising stop for 10 cycles mid-count delays the timeout by exactly 10 cycles.
REQ-036 SHALL test collision: TICLR write on the exact timeout cycle -> pending remains 1; TCFG write on the timeout cycle -> TVAL equals the new load value and pending=1.
REQ-037 SHALL test masking and reset: write TCFG with wmask=0x1 only -> InitVal unchanged; assert reset mid-count -> TVAL=0xFFFF_FFFF, irq=0, ISTAT=0.

Source files
------------

// File: rtl/csr_timer_bank_pkg.sv
// Shared CSR map for the timer bank: channel register offsets and global addresses.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package csr_timer_bank_pkg;

  // Register offset within a 4-word channel window (channel i lives at 4*i).
  typedef enum logic [1:0] {
    CH_TCFG  = 2'd0,
    CH_TVAL  = 2'd1,
    CH_TICLR = 2'd2,
    CH_RSVD  = 2'd3
  } ch_reg_e;

  localparam logic [1:0] OFS_TCFG  = 2'd0;
  localparam logic [1:0] OFS_TVAL  = 2'd1;
  localparam logic [1:0] OFS_TICLR = 2'd2;

  // Global registers sit above the channel windows.
  localparam logic [7:0] ADDR_PRESC = 8'hF0;
  localparam logic [7:0] ADDR_IMASK = 8'hF1;
  localparam logic [7:0] ADDR_ISTAT = 8'hF2;

  localparam int MAX_NCH = 16;

endpackage

// File: rtl/csr_timer_bank_timer_channel.sv
// One timer channel: TCFG {InitVal, Periodic, En}, down-counter TVAL and pending flag.
// Latency: CSR writes land on the next edge; pending sets on the edge of the timeout tick.
// Backpressure: none; writes and ticks are always accepted.
// Ports: clk/reset, tick_i (shared prescaler tick), cfg_we_i/cfg_wdata_i/cfg_wmask_i (TCFG write),
//        clr_i (pending clear), cfg_o/tval_o/pending_o (register state for readback and irq).
module timer_channel
  import csr_timer_bank_pkg::*;
#(
  parameter int TW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick_i,
  input  logic          cfg_we_i,
  input  logic [TW-1:0] cfg_wdata_i,
  input  logic [TW-1:0] cfg_wmask_i,
  input  logic          clr_i,
  output logic [TW-1:0] cfg_o,
  output logic [TW-1:0] tval_o,
  output logic          pending_o
);

  logic [TW-1:0] cfg_q, cfg_d;
  logic [TW-1:0] tval_q, tval_d;
  logic          pending_q, pending_d;
  logic [TW-1:0] cfg_merged;
  logic          en, periodic, timeout;

  assign cfg_merged = (cfg_wmask_i & cfg_wdata_i) | (~cfg_wmask_i & cfg_q);
  assign en         = cfg_q[0];
  assign periodic   = cfg_q[1];
  assign timeout    = en && tick_i && (tval_q == '0);

  always_comb begin
    cfg_d     = cfg_q;
    tval_d    = tval_q;
    pending_d = pending_q;

    // A timeout set beats a same-cycle clear so no event is lost.
    if (timeout) begin
      pending_d = 1'b1;
    end else if (clr_i) begin
      pending_d = 1'b0;
    end

    // A TCFG write owns TVAL/En/Periodic even on the timeout cycle;
    // with the merged En low the counter simply holds.
    if (cfg_we_i) begin
      cfg_d = cfg_merged;
      if (cfg_merged[0]) begin
        tval_d = {cfg_merged[TW-1:2], 2'b00};
      end
    end else if (en && tick_i) begin
      if (tval_q != '0) begin
        tval_d = tval_q - TW'(1);
      end else if (periodic) begin
        tval_d = {cfg_q[TW-1:2], 2'b00};
      end else begin
        // One-shot: park at all-ones and stop.
        tval_d   = '1;
        cfg_d[0] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_q     <= '0;
      tval_q    <= '1;
      pending_q <= 1'b0;
    end else begin
      cfg_q     <= cfg_d;
      tval_q    <= tval_d;
      pending_q <= pending_d;
    end
  end

  assign cfg_o     = cfg_q;
  assign tval_o    = tval_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/csr_timer_bank.sv
// Bank of NCH CSR-programmed down-counting timers sharing one prescaled tick, with masked irq.
// Latency: rdata is combinational on addr; writes take effect on the next edge.
// Backpressure: none; stop freezes the prescaler and therefore all counting.
// Ports: clk/reset, addr/we/wdata/wmask (CSR write), rdata (CSR read), stop (debug freeze),
//        irq_pending (per-channel pending flags), irq (OR of pending & IMASK).
module csr_timer_bank
  import csr_timer_bank_pkg::*;
#(
  parameter int NCH = 4,
  parameter int TW  = 32,
  parameter int PSW = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [7:0]     addr,
  input  logic           we,
  input  logic [31:0]    wdata,
  input  logic [31:0]    wmask,
  output logic [31:0]    rdata,
  input  logic           stop,
  output logic [NCH-1:0] irq_pending,
  output logic           irq
);

  logic [PSW-1:0] presc_q, presc_d;
  logic [PSW-1:0] pcnt_q, pcnt_d;
  logic [NCH-1:0] imask_q, imask_d;
  logic           tick, presc_wr, imask_wr;

  logic [3:0]     ch_idx;
  ch_reg_e        ch_reg;
  logic           ch_hit;
  logic [NCH-1:0] cfg_we, clr;
  logic [TW-1:0]  cfg_rd  [NCH];
  logic [TW-1:0]  tval_rd [NCH];

  // Channel windows occupy 0x00..0x3F; only the first NCH windows are populated.
  assign ch_idx = addr[5:2];
  assign ch_reg = ch_reg_e'(addr[1:0]);
  assign ch_hit = (addr[7:6] == 2'b00) && (int'(ch_idx) < NCH);

  assign presc_wr = we && (addr == ADDR_PRESC);
  assign imask_wr = we && (addr == ADDR_IMASK);

  // Shared tick; stop suppresses it and holds pcnt so the whole bank freezes.
  assign tick = (pcnt_q == presc_q) && !stop;

  always_comb begin
    presc_d = presc_q;
    imask_d = imask_q;
    if (presc_wr) begin
      presc_d = (wmask[PSW-1:0] & wdata[PSW-1:0]) | (~wmask[PSW-1:0] & presc_q);
    end
    if (imask_wr) begin
      imask_d = (wmask[NCH-1:0] & wdata[NCH-1:0]) | (~wmask[NCH-1:0] & imask_q);
    end

    if (presc_wr || tick) begin
      pcnt_d = '0;
    end else if (stop) begin
      pcnt_d = pcnt_q;
    end else begin
      pcnt_d = pcnt_q + PSW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      pcnt_q  <= '0;
      imask_q <= '0;
    end else begin
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
      imask_q <= imask_d;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign cfg_we[i] = we && ch_hit && (ch_idx == 4'(i)) && (ch_reg == CH_TCFG);
    assign clr[i]    = we && ch_hit && (ch_idx == 4'(i)) && (ch_reg == CH_TICLR) && wdata[0];

    timer_channel #(.TW(TW)) u_ch (
      .clk        (clk),
      .reset      (reset),
      .tick_i     (tick),
      .cfg_we_i   (cfg_we[i]),
      .cfg_wdata_i(wdata[TW-1:0]),
      .cfg_wmask_i(wmask[TW-1:0]),
      .clr_i      (clr[i]),
      .cfg_o      (cfg_rd[i]),
      .tval_o     (tval_rd[i]),
      .pending_o  (irq_pending[i])
    );
  end

  assign irq = |(irq_pending & imask_q);

  // Read mux; TICLR, the reserved slot and unmapped addresses return 0.
  always_comb begin
    rdata = '0;
    if (ch_hit) begin
      for (int i = 0; i < NCH; i++) begin
        if (ch_idx == 4'(i)) begin
          case (ch_reg)
            CH_TCFG: rdata[TW-1:0] = cfg_rd[i];
            CH_TVAL: rdata[TW-1:0] = tval_rd[i];
            default: rdata = '0;
          endcase
        end
      end
    end else begin
      case (addr)
        ADDR_PRESC: rdata[PSW-1:0] = presc_q;
        ADDR_IMASK: rdata[NCH-1:0] = imask_q;
        ADDR_ISTAT: rdata[NCH-1:0] = irq_pending;
        default:    rdata = '0;
      endcase
    end
  end

endmodule
